// File: rtl/hybrid_arith_pkg.sv
// Shared constants for the HybridCore arithmetic unit (multiplier and divider).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding shared by the start/done sequencers and the
// default operand width used by both the multiplier and the reciprocal divider.
package hybrid_arith_pkg;

    // Default operand width; results use the 8.8 fixed-point convention.
    localparam int ARITH_W = 8;

    // Sequencer state encoding (kept as plain constants for legacy tooling).
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/done request bus between the arithmetic unit and the sequential multiplier.
// Latency: n/a (wires only).
// Backpressure: requester watches busy; a start seen while busy is dropped by the slave.
//
// Signals: start (req), a/b (operands, WIDTH), busy, done (1-cycle pulse),
// product (2*WIDTH, held until the next accepted request completes).
// master = requester, slave = multiplier.
interface seq_multiplier_if
    import hybrid_arith_pkg::*;
#(
    parameter int WIDTH = ARITH_W
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_step.sv
// One shift-and-add iteration of the sequential multiplier (purely combinational).
// Latency: 0 cycles.
// Backpressure: none; evaluated every cycle, the caller decides when to register.
//
// Ports: acc/mcand (2*WIDTH) and mplier (WIDTH) in; next acc, mcand, mplier out.
module shift_add_step #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic [2*WIDTH-1:0] mcand_nxt,
    output logic [WIDTH-1:0]   mplier_nxt
);
    // Sum wraps modulo 2^(2*WIDTH); a WIDTH x WIDTH product never exceeds that.
    assign acc_nxt    = mplier[0] ? (acc + mcand) : acc;
    assign mcand_nxt  = mcand << 1;
    assign mplier_nxt = mplier >> 1;
endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock.
// Latency: fixed; start sampled at edge k gives done high in the cycle after edge k+WIDTH.
// Backpressure: start is ignored while busy (no queueing); accepted in IDLE or in the done cycle.
//
// Ports: clk, rst (synchronous, active-high), bus (seq_multiplier_if.slave).
// Build option: define SEQ_MULT_SIGNED_EN for two's-complement operands
// (magnitudes are multiplied and the sign applied when the result lands).
module seq_multiplier
    import hybrid_arith_pkg::*;
#(
    parameter int WIDTH = ARITH_W
) (
    input  logic               clk,
    input  logic               rst,
    seq_multiplier_if.slave    bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]       state;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    product_q;

    logic [PW-1:0]    acc_nxt;
    logic [PW-1:0]    mcand_nxt;
    logic [WIDTH-1:0] mplier_nxt;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    result;

    shift_add_step #(.WIDTH(WIDTH)) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .acc_nxt    (acc_nxt),
        .mcand_nxt  (mcand_nxt),
        .mplier_nxt (mplier_nxt)
    );

    // start only counts when no operation is in flight.
    assign accept = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last   = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_MULT_SIGNED_EN
    logic sign_q;

    // |most-negative| is 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
    always_comb begin
        a_mag = bus.a[WIDTH-1] ? (-bus.a) : bus.a;
        b_mag = bus.b[WIDTH-1] ? (-bus.b) : bus.b;
    end

    // The last step's sum is used directly so the product lands on the RUN->DONE edge.
    assign result = sign_q ? (-acc_nxt) : acc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q <= 1'b0;
        end else if (accept) begin
            sign_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end
    end
`else
    assign a_mag  = bus.a;
    assign b_mag  = bus.b;
    assign result = acc_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else if (accept) begin
            // product_q is left alone: the previous result stays visible until the new one lands.
            state  <= ST_RUN;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            cnt    <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand_nxt;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        state     <= ST_DONE;
                        product_q <= result;
                    end
                end
                // DONE without a new start, and any unused encoding, fall back to IDLE.
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = (state == ST_RUN);
    assign bus.done    = (state == ST_DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed-vector bench for seq_multiplier (WIDTH=8).
// Latency: checks done arrives exactly 8 cycles after start is sampled.
// Backpressure: checks start-while-busy is dropped and start-in-done is accepted.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst;

    seq_multiplier_if #(.WIDTH(8)) bus ();

    seq_multiplier #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          lat;
    int          busy_cnt;
    int          n_done;
    logic [15:0] held_product;
    logic        held_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for done; also counts cycles seen busy on the way.
    task automatic wait_done(output int cyc);
        cyc = 0;
        busy_cnt = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) busy_cnt++;
            tick();
            cyc++;
        end
    endtask

    task automatic count_done(input int cycles, output int k);
        k = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.done) k++;
            tick();
        end
    endtask

    // Issue one request, scramble the inputs after acceptance, and check the result.
    task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] exp, input string tag);
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        tick();
        bus.start    = 1'b0;
        held_product = bus.product;
        held_done    = bus.done;
        bus.a        = ~x;
        bus.b        = ~y;
        wait_done(lat);
        chk({tag, "_latency"}, lat, 8);
        chk({tag, "_busy_cycles"}, busy_cnt, 8);
        chk({tag, "_product"}, {16'h0, bus.product}, {16'h0, exp});
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        tick();
        tick();
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_product", bus.product, 0);
        rst = 1'b0;
        tick();

`ifdef SEQ_MULT_SIGNED_EN
        do_op(8'hFF, 8'hFF, 16'h0001, "s_m1_x_m1");
        tick();
        do_op(8'h80, 8'h7F, 16'hC080, "s_m128_x_127");
        tick();
        do_op(8'h05, 8'hFD, 16'hFFF1, "s_5_x_m3");
        tick();
        do_op(8'h80, 8'h80, 16'h4000, "s_m128_x_m128");
        tick();
`else
        do_op(8'hFF, 8'hFF, 16'hFE01, "ff_x_ff");
        tick();
        chk("ff_done_pulse_width", bus.done, 0);
        chk("ff_back_to_idle", bus.busy, 0);
`endif

        // No early-out for a zero multiplicand.
        do_op(8'h00, 8'hA5, 16'h0000, "zero_x_a5");
        tick();
        chk("zero_done_pulse_width", bus.done, 0);

        // Back-to-back: second start lands in the done cycle of the first.
        do_op(8'd7, 8'd9, 16'h003F, "b2b_first");
        do_op(8'd12, 8'd12, 16'h0090, "b2b_second");
        chk("b2b_product_held", held_product, 16'h003F);
        chk("b2b_done_dropped", held_done, 0);
        tick();

        // start during RUN is ignored; operands are not re-captured.
        bus.a     = 8'd3;
        bus.b     = 8'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.a     = 8'd200;
        bus.b     = 8'd100;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(lat);
        chk("busy_start_latency", lat, 5);
        chk("busy_start_product", bus.product, 16'h000F);
        tick();
        count_done(12, n_done);
        chk("busy_start_single_done", n_done, 0);

        // Reset in the middle of RUN aborts with no done.
        bus.a     = 8'd9;
        bus.b     = 8'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_product", bus.product, 0);
        rst = 1'b0;
        count_done(12, n_done);
        chk("abort_no_done", n_done, 0);
        chk("abort_idle", bus.busy, 0);

        // rst and start on the same edge: rst wins.
        bus.a     = 8'd4;
        bus.b     = 8'd4;
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("rst_beats_start_busy", bus.busy, 0);
        tick();
        chk("rst_beats_start_still_idle", bus.busy, 0);

        // Recovery after abort.
        do_op(8'd6, 8'd7, 16'h002A, "recover_6_x_7");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
